// File: rtl/rf_pkg.sv
// Shared definitions for the operand-fetch stage.
// The state enum is used by operand_fetch.
package rf_pkg;
   localparam int XLEN       = 32;
   localparam int NumEntries = 32;
   localparam int RegIdxW    = $clog2(NumEntries);

   typedef enum logic [1:0] {EMPTY, FULL, STALL} state_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with RAW/WAW hazard detection.
// Writeback forwarding masks RAW hazards only.
module rf_scoreboard #(
   parameter int  NumEntries = 32,
   localparam int RegIdxW    = $clog2(NumEntries)
) (
   input  logic               clk_100MHz,
   input  logic               reset,
   input  logic               set_en,
   input  logic [RegIdxW-1:0] set_idx,
   input  logic               clr_en,
   input  logic [RegIdxW-1:0] clr_idx,
   input  logic [RegIdxW-1:0] rs1,
   input  logic [RegIdxW-1:0] rs2,
   input  logic [RegIdxW-1:0] rd,
   input  logic               rd_we,
   output logic               hazard,
   output logic               fwd1,
   output logic               fwd2
);

   logic [NumEntries-1:0] busy;
   logic [NumEntries-1:0] busy_next;

   // The clear is applied first so that a same-cycle set wins.
   always_comb begin
      busy_next = busy;
      if (clr_en) busy_next[clr_idx] = 1'b0;
      if (set_en) busy_next[set_idx] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) busy <= '0;
      else       busy <= busy_next;
   end

   assign fwd1 = clr_en && (clr_idx == rs1) && (rs1 != '0);
   assign fwd2 = clr_en && (clr_idx == rs2) && (rs2 != '0);

   assign hazard = (busy[rs1] && !fwd1) || (busy[rs2] && !fwd2) || (rd_we && busy[rd]);

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads sources, forwards same-cycle writeback,
// stalls on scoreboard hazards and registers a one-deep operand bundle.
module operand_fetch
   import rf_pkg::XLEN, rf_pkg::state_t, rf_pkg::EMPTY, rf_pkg::FULL, rf_pkg::STALL;
#(
   parameter int  NumEntries = 32,
   localparam int RegIdxW    = $clog2(NumEntries),
   localparam int AddrW      = $clog2(NumEntries * 4)
) (
   input  logic               clk_100MHz,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [RegIdxW-1:0] in_rs1,
   input  logic [RegIdxW-1:0] in_rs2,
   input  logic [RegIdxW-1:0] in_rd,
   input  logic               in_rd_we,
   output logic               rf_readEn,
   output logic               rf_readEn_2,
   output logic [AddrW-1:0]   rf_readAddr,
   output logic [AddrW-1:0]   rf_readAddr_2,
   input  logic [XLEN-1:0]    rf_readData,
   input  logic [XLEN-1:0]    rf_readData_2,
   input  logic               wb_valid,
   input  logic [RegIdxW-1:0] wb_rd,
   input  logic [XLEN-1:0]    wb_data,
   output logic               rf_writeEn,
   output logic [AddrW-1:0]   rf_writeAddr,
   output logic [XLEN-1:0]    rf_writeData,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_rs1_val,
   output logic [XLEN-1:0]    out_rs2_val,
   output logic [RegIdxW-1:0] out_rd,
   output logic               out_rd_we,
   output logic [15:0]        stall_cnt
);

   state_t           state;
   state_t           state_next;
   logic             hazard;
   logic             fwd1;
   logic             fwd2;
   logic             accept;
   logic [XLEN-1:0]  rs1_val;
   logic [XLEN-1:0]  rs2_val;

   assign rf_writeEn    = wb_valid && (wb_rd != '0);
   assign rf_writeAddr  = AddrW'({wb_rd, 2'b00});
   assign rf_writeData  = wb_data;

   assign rf_readEn     = in_valid;
   assign rf_readEn_2   = in_valid;
   assign rf_readAddr   = AddrW'(in_rs1);
   assign rf_readAddr_2 = AddrW'(in_rs2);

   rf_scoreboard #(.NumEntries(NumEntries)) u_scoreboard (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .set_en     (accept && in_rd_we && (in_rd != '0)),
      .set_idx    (in_rd),
      .clr_en     (wb_valid),
      .clr_idx    (wb_rd),
      .rs1        (in_rs1),
      .rs2        (in_rs2),
      .rd         (in_rd),
      .rd_we      (in_rd_we),
      .hazard     (hazard),
      .fwd1       (fwd1),
      .fwd2       (fwd2)
   );

   assign in_ready = !reset && !hazard && ((state == EMPTY) || out_ready);
   assign accept   = in_valid && in_ready;

   assign rs1_val = (in_rs1 == '0) ? '0 : (fwd1 ? wb_data : rf_readData);
   assign rs2_val = (in_rs2 == '0) ? '0 : (fwd2 ? wb_data : rf_readData_2);

   always_ff @(posedge clk_100MHz) begin
      if (reset) state <= EMPTY;
      else       state <= state_next;
   end

   // FULL holds while downstream back-pressures; otherwise refill, stall or drain.
   always_comb begin
      state_next = state;
      if (state == FULL && !out_ready) state_next = FULL;
      else if (accept)                 state_next = FULL;
      else if (in_valid && hazard)     state_next = STALL;
      else                             state_next = EMPTY;
   end

   assign out_valid = (state == FULL);

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         out_rs1_val <= '0;
         out_rs2_val <= '0;
         out_rd      <= '0;
         out_rd_we   <= 1'b0;
      end else if (accept) begin
         out_rs1_val <= rs1_val;
         out_rs2_val <= rs2_val;
         out_rd      <= in_rd;
         out_rd_we   <= in_rd_we;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset)                                     stall_cnt <= '0;
      else if (in_valid && hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a vector table for the combinational
// read/writeback paths, then hand-written multi-cycle hazard and flow sequences.
module tb_operand_fetch;

   logic        clk_100MHz = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_rd_we;
   logic        rf_readEn, rf_readEn_2;
   logic [6:0]  rf_readAddr, rf_readAddr_2;
   logic [31:0] rf_readData, rf_readData_2;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        rf_writeEn;
   logic [6:0]  rf_writeAddr;
   logic [31:0] rf_writeData;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rs1_val, out_rs2_val;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   logic preload = 1'b0;
   logic [31:0] rf [32];

   always #5 clk_100MHz = ~clk_100MHz;

   operand_fetch #(.NumEntries(32)) dut (
      .clk_100MHz    (clk_100MHz),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rs1        (in_rs1),
      .in_rs2        (in_rs2),
      .in_rd         (in_rd),
      .in_rd_we      (in_rd_we),
      .rf_readEn     (rf_readEn),
      .rf_readEn_2   (rf_readEn_2),
      .rf_readAddr   (rf_readAddr),
      .rf_readAddr_2 (rf_readAddr_2),
      .rf_readData   (rf_readData),
      .rf_readData_2 (rf_readData_2),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .rf_writeEn    (rf_writeEn),
      .rf_writeAddr  (rf_writeAddr),
      .rf_writeData  (rf_writeData),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_rs1_val   (out_rs1_val),
      .out_rs2_val   (out_rs2_val),
      .out_rd        (out_rd),
      .out_rd_we     (out_rd_we),
      .stall_cnt     (stall_cnt)
   );

   // Register-file model; x0 holds a nonzero value so the zero-index override is visible.
   always @(posedge clk_100MHz) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h1000 + 32'(i);
      end else if (rf_writeEn) begin
         rf[rf_writeAddr[6:2]] <= rf_writeData;
      end
   end

   assign rf_readData   = rf[rf_readAddr[4:0]];
   assign rf_readData_2 = rf[rf_readAddr_2[4:0]];

   typedef struct {
      logic        wv;
      logic [4:0]  wrd;
      logic [31:0] wdata;
      logic        iv;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        exp_we;
      logic [6:0]  exp_waddr;
      logic        exp_ren;
      logic [6:0]  exp_raddr1;
      logic [6:0]  exp_raddr2;
   } vec_t;

   vec_t vecs[4];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic rdwe, input logic ordy,
                                input logic wv, input logic [4:0] wrd, input logic [31:0] wdata);
      in_valid  = iv;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_rd     = rd;
      in_rd_we  = rdwe;
      out_ready = ordy;
      wb_valid  = wv;
      wb_rd     = wrd;
      wb_data   = wdata;
   endtask

   task automatic step();
      @(posedge clk_100MHz);
      @(negedge clk_100MHz);
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd5,  32'h11,   1'b1, 5'd3, 5'd31, 1'b1, 7'h14, 1'b1, 7'd3, 7'd31};
      vecs[1] = '{1'b1, 5'd0,  32'hDEAD, 1'b0, 5'd5, 5'd6,  1'b0, 7'h00, 1'b0, 7'd5, 7'd6};
      vecs[2] = '{1'b0, 5'd31, 32'h99,   1'b1, 5'd0, 5'd1,  1'b0, 7'h7C, 1'b1, 7'd0, 7'd1};
      vecs[3] = '{1'b1, 5'd6,  32'h22,   1'b0, 5'd0, 5'd0,  1'b1, 7'h18, 1'b0, 7'd0, 7'd0};

      reset = 1'b1;
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      preload = 1'b1;
      step();
      preload = 1'b0;

      // Combinational paths under reset; the writebacks also preload x5 and x6.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].iv, vecs[i].rs1, vecs[i].rs2, 5'd0, 1'b0, 1'b1,
                       vecs[i].wv, vecs[i].wrd, vecs[i].wdata);
         #1;
         checkOutput("vec_writeEn",   32'(rf_writeEn),    32'(vecs[i].exp_we));
         checkOutput("vec_writeAddr", 32'(rf_writeAddr),  32'(vecs[i].exp_waddr));
         checkOutput("vec_writeData", rf_writeData,       vecs[i].wdata);
         checkOutput("vec_readEn",    32'(rf_readEn),     32'(vecs[i].exp_ren));
         checkOutput("vec_readEn_2",  32'(rf_readEn_2),   32'(vecs[i].exp_ren));
         checkOutput("vec_readAddr",  32'(rf_readAddr),   32'(vecs[i].exp_raddr1));
         checkOutput("vec_readAddr_2",32'(rf_readAddr_2), 32'(vecs[i].exp_raddr2));
         checkOutput("vec_in_ready_reset", 32'(in_ready), 32'd0);
         step();
      end

      reset = 1'b0;
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("rst_out_valid",   32'(out_valid),   32'd0);
      checkOutput("rst_out_rs1_val", out_rs1_val,      32'h0);
      checkOutput("rst_out_rs2_val", out_rs2_val,      32'h0);
      checkOutput("rst_out_rd",      32'(out_rd),      32'd0);
      checkOutput("rst_out_rd_we",   32'(out_rd_we),   32'd0);
      checkOutput("rst_stall_cnt",   32'(stall_cnt),   32'd0);
      checkOutput("rst_in_ready",    32'(in_ready),    32'd1);

      // Basic issue with one-cycle latency.
      @(negedge clk_100MHz);
      applyStimulus(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("a_in_ready", 32'(in_ready), 32'd1);
      step();
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("a_out_valid", 32'(out_valid), 32'd1);
      checkOutput("a_rs1_val",   out_rs1_val,    32'h11);
      checkOutput("a_rs2_val",   out_rs2_val,    32'h22);
      checkOutput("a_out_rd",    32'(out_rd),    32'd7);
      checkOutput("a_out_rd_we", 32'(out_rd_we), 32'd1);

      // RAW on x7: stall two cycles, then release with forwarded writeback.
      @(negedge clk_100MHz);
      applyStimulus(1'b1, 5'd7, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("b_in_ready_haz", 32'(in_ready), 32'd0);
      step();
      checkOutput("b_out_valid_stall", 32'(out_valid), 32'd0);
      checkOutput("b_stall_cnt1",      32'(stall_cnt), 32'd1);
      step();
      checkOutput("b_stall_cnt2", 32'(stall_cnt), 32'd2);
      applyStimulus(1'b1, 5'd7, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 5'd7, 32'hAB);
      #1;
      checkOutput("b_in_ready_fwd", 32'(in_ready), 32'd1);
      step();
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("b_out_valid",  32'(out_valid), 32'd1);
      checkOutput("b_rs1_val",    out_rs1_val,    32'hAB);
      checkOutput("b_rs2_val",    out_rs2_val,    32'h0);
      checkOutput("b_out_rd",     32'(out_rd),    32'd8);
      checkOutput("b_stall_hold", 32'(stall_cnt), 32'd2);

      // x0 sources and destination; writeback to x0 is suppressed.
      @(negedge clk_100MHz);
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 32'h55);
      #1;
      checkOutput("c_writeEn_x0", 32'(rf_writeEn), 32'd0);
      checkOutput("c_in_ready",   32'(in_ready),   32'd1);
      step();
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("c_rs1_zero",     out_rs1_val,   32'h0);
      checkOutput("c_rs2_zero",     out_rs2_val,   32'h0);
      checkOutput("c_out_rd",       32'(out_rd),   32'd0);
      checkOutput("c_no_busy_x0",   32'(in_ready), 32'd1);

      // Back-pressure for three cycles, then a back-to-back transfer.
      applyStimulus(1'b1, 5'd5, 5'd6, 5'd10, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      step();
      applyStimulus(1'b1, 5'd6, 5'd5, 5'd11, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("d_in_ready_bp", 32'(in_ready),  32'd0);
         checkOutput("d_valid_hold",  32'(out_valid), 32'd1);
         checkOutput("d_rs1_hold",    out_rs1_val,    32'h11);
         checkOutput("d_rs2_hold",    out_rs2_val,    32'h22);
         checkOutput("d_rd_hold",     32'(out_rd),    32'd10);
         step();
      end
      out_ready = 1'b1;
      #1;
      checkOutput("d_in_ready_go", 32'(in_ready), 32'd1);
      step();
      checkOutput("d_b2b_valid", 32'(out_valid), 32'd1);
      checkOutput("d_b2b_rs1",   out_rs1_val,    32'h22);
      checkOutput("d_b2b_rs2",   out_rs2_val,    32'h11);
      checkOutput("d_b2b_rd",    32'(out_rd),    32'd11);

      // Reset while FULL with x9 busy.
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      step();
      applyStimulus(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("e_busy9_pre", 32'(in_ready), 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("e_in_ready_rst", 32'(in_ready), 32'd0);
      step();
      reset = 1'b0;
      #1;
      checkOutput("e_out_valid_rst", 32'(out_valid), 32'd0);
      checkOutput("e_stall_cnt_rst", 32'(stall_cnt), 32'd0);
      checkOutput("e_in_ready_x9",   32'(in_ready),  32'd1);
      step();
      checkOutput("e_out_valid", 32'(out_valid), 32'd1);
      checkOutput("e_rs1_val",   out_rs1_val,    32'h1009);

      // Same-cycle clear and set of x4: the set must survive.
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 32'h44);
      #1;
      checkOutput("f_in_ready", 32'(in_ready), 32'd1);
      step();
      applyStimulus(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("f_busy4_set", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h77);
      #1;
      checkOutput("f_fwd2_ready", 32'(in_ready), 32'd1);
      step();
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput("f_rs2_fwd",   out_rs2_val,    32'h77);
      checkOutput("f_rs1_zero",  out_rs1_val,    32'h0);
      checkOutput("f_stall_cnt", 32'(stall_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL take parameter NumEntries, default 32: number of architectural registers (RegIdxW = $clog2(NumEntries)).
REQ-002 The block SHALL have these ports:
- clk_100MHz  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded instruction offered.
- in_ready  out  1  instruction accepted this cycle when high with in_valid.
- in_rs1, in_rs2, in_rd  in  RegIdxW  source and destination register indices.
- in_rd_we  in  1  instruction writes in_rd.
- rf_readEn, rf_readEn_2  out  1  register-file read enables.
- rf_readAddr, rf_readAddr_2  out  $clog2(NumEntries*4)  word index of rs1/rs2, zero-extended.
- rf_readData, rf_readData_2  in  32  combinational read data.
- wb_valid  in  1  writeback strobe.
- wb_rd  in  RegIdxW  writeback destination.
- wb_data  in  32  writeback value.
- rf_writeEn  out  1  register-file write enable.
- rf_writeAddr  out  $clog2(NumEntries*4)  byte address, wb_rd<<2.
- rf_writeData  out  32  write value.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_rs1_val, out_rs2_val  out  32  operand values.
- out_rd  out  RegIdxW  destination index.
- out_rd_we  out  1  destination write flag.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-003 Writeback SHALL be combinational pass-through: rf_writeEn=wb_valid && wb_rd!=0; rf_writeAddr=wb_rd<<2; rf_writeData=wb_data.
REQ-004 Read ports SHALL be driven combinationally from in_rs1/in_rs2 with rf_readEn=rf_readEn_2=in_valid.
REQ-005 A scoreboard SHALL hold one busy bit per register; bit 0 SHALL always read 0.
REQ-006 On acceptance with in_rd_we=1 and in_rd!=0, busy[in_rd] SHALL be set at the next edge.
REQ-007 wb_valid SHALL clear busy[wb_rd] at the next edge.
REQ-008 When a set and a clear hit the same register in one cycle, the set SHALL win.
REQ-009 hazard SHALL equal (busy[in_rs1] && !fwd1) || (busy[in_rs2] && !fwd2) || (in_rd_we && busy[in_rd]).
REQ-010 fwd1 SHALL equal wb_valid && wb_rd==in_rs1 && in_rs1!=0; fwd2 SHALL be defined likewise for in_rs2.
REQ-011 The WAW term SHALL ignore same-cycle writeback and stall until busy clears.
REQ-012 Operand selection SHALL be: index 0 -> 0; else fwdN -> wb_data; else rf_readData (rs1) / rf_readData_2 (rs2).
REQ-013 in_ready SHALL equal !hazard && (state==EMPTY || out_ready).
REQ-014 The FSM SHALL have states EMPTY, FULL and STALL.
REQ-015 From EMPTY or STALL: acceptance -> FULL; in_valid && hazard -> STALL; otherwise -> EMPTY.
REQ-016 From FULL: out_ready && acceptance -> FULL; out_ready && in_valid && hazard -> STALL; out_ready otherwise -> EMPTY; !out_ready -> FULL.
REQ-017 out_valid SHALL be 1 exactly in FULL.
REQ-018 Bundle latency SHALL be one cycle: the bundle is registered at the acceptance edge.
REQ-019 While FULL and !out_ready, all out_* SHALL hold stable.
REQ-020 stall_cnt SHALL increment each cycle in_valid && hazard and saturate at 16'hFFFF.

Reset
REQ-021 On reset, state SHALL become EMPTY and all busy bits SHALL clear.
REQ-022 On reset, out_valid, out_rs1_val, out_rs2_val, out_rd, out_rd_we and stall_cnt SHALL become 0.
REQ-023 Reset asserted mid-operation SHALL discard any held bundle; in_ready SHALL be 0 during reset.

Structure
REQ-024 Shared package rf_pkg SHALL hold XLEN=32, NumEntries, RegIdxW and the state enum {EMPTY, FULL, STALL}.
REQ-025 The busy-bit array and hazard logic SHALL live in sub-module rf_scoreboard; all else SHALL be in operand_fetch.

Verification
REQ-026 The bench SHALL cover: preload x5=0x11, x6=0x22; issue rs1=5, rs2=6, rd=7 -> next cycle out_valid=1, out_rs1_val=0x11, out_rs2_val=0x22, out_rd=7.
REQ-027 The bench SHALL cover: issue rd=7 write, then rs1=7 with no writeback -> in_ready=0, STALL; stall_cnt increments; wb_valid, wb_rd=7, wb_data=0xAB -> accepted that cycle, out_rs1_val=0xAB.
REQ-028 The bench SHALL cover: rs1=0, rs2=0, rd=0 with rd_we=1 -> operands 0, no busy bit set; wb_rd=0 -> rf_writeEn=0.
REQ-029 The bench SHALL cover: out_ready=0 for 3 cycles while FULL -> outputs stable, in_ready=0; out_ready=1 with new valid instruction -> back-to-back transfer.
REQ-030 The bench SHALL cover: reset while FULL with busy[9]=1 -> next cycle out_valid=0, busy cleared, new rs1=9 accepted immediately.
REQ-031 The bench SHALL cover: same-cycle wb_rd=4 clear and accept of rd=4 -> busy[4]=1 afterwards.
